cail_cmd_parser: RTL and testbench
==================================

Name: cail_cmd_parser

Overview:
- UART-side command front end for the calibration parameter store. Sits directly upstream of the calibration parameter controller.
- Consumes bytes from the UART receiver and decodes fixed 6-byte frames.
- Drives the controller's wr_req/rd_req/update_req handshakes, then returns a 4-byte reply frame through the UART transmitter.

Parameters:
- RD_HOLD, 6, cycles rd_req is held high; rd_data is sampled on the last held cycle.
- WR_HOLD, 4, cycles wr_req is held high with wr_addr/wr_data stable.
- SAVE_WAIT, 24'd5_000_000, cycles after update_req during which new frames are ignored (EEPROM write time).
- BYTE_TIMEOUT, 20'd500_000, maximum idle cycles between bytes of one frame before the frame is discarded.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- tx_en  out  1  one-cycle strobe to start sending tx_data
- tx_data  out  8  byte to transmit
- tx_done  in  1  one-cycle strobe, transmitter finished the byte
- init_done  in  1  controller has loaded EEPROM into RAM (pulse; latched internally)
- wr_req  out  1  write request to the controller
- wr_addr  out  10  write address
- wr_data  out  8  write data
- rd_req  out  1  read request to the controller
- rd_addr  out  10  read address
- rd_data  in  8  read data from the controller
- update_req  out  1  one-cycle pulse: save RAM to EEPROM
- err_pulse  out  1  one-cycle pulse on any rejected frame

Behaviour:
- Reset: all outputs 0; state RX_HDR; ready flag (latched init_done) 0; byte counter 0; checksum 0.
- ready flag sets on the first cycle init_done is high and clears only on reset.
- Request frame: 0x55, CMD, ADDR_H, ADDR_L, DATA, SUM.
  - Address = {ADDR_H[1:0], ADDR_L}; ADDR_H[7:2] are ignored.
  - SUM = (CMD+ADDR_H+ADDR_L+DATA) mod 256.
- Commands: 0x01 write, 0x02 read, 0x03 save.
- Reply frame: 0xAA, RCMD, RDATA, RSUM, where RSUM = (RCMD+RDATA) mod 256.
  - Success: RCMD = CMD. RDATA = DATA for write, rd_data for read, 0x00 for save.
  - Error: RCMD = 0xEE, RDATA = error code: 0x01 bad checksum, 0x02 unknown CMD, 0x03 not ready.
- States:
  - RX_HDR: a byte equal to 0x55 -> RX_BODY, counter = 0. Any other byte is dropped silently.
  - RX_BODY: store 5 bytes. The 5th byte -> CHECK. The idle counter resets on every rx_valid; reaching BYTE_TIMEOUT -> RX_HDR with no reply and no err_pulse. A 0x55 inside the body is treated as data.
  - CHECK (1 cycle): error priority is checksum > unknown CMD > not ready. Error -> TX_LOAD with the error reply and err_pulse = 1 for this cycle. Otherwise go to EXEC_WR, EXEC_RD or EXEC_SAVE.
  - EXEC_WR: wr_addr/wr_data driven from CHECK onward and held until the next frame executes. wr_req = 1 for exactly WR_HOLD cycles -> TX_LOAD.
  - EXEC_RD: rd_addr driven from CHECK onward. rd_req = 1 for exactly RD_HOLD cycles; rd_data is captured on the last high cycle -> TX_LOAD.
  - EXEC_SAVE: update_req = 1 for one cycle -> TX_LOAD. A save reply is followed by WAIT_SAVE.
  - TX_LOAD: tx_data = current reply byte, tx_en = 1 for one cycle -> TX_WAIT.
  - TX_WAIT: on tx_done, if 4 bytes are sent -> RX_HDR (or WAIT_SAVE after a save reply); otherwise next byte -> TX_LOAD.
  - WAIT_SAVE: count SAVE_WAIT cycles; rx bytes are discarded -> RX_HDR.
- rx_valid outside RX_HDR/RX_BODY is ignored; no buffering.
- wr_req and rd_req are never high together. update_req never overlaps either.
- tx_done while not in TX_WAIT is ignored.
- Reset mid-operation: all requests drop immediately; the partial frame is discarded.

Test Plan:
- After init_done, send 55 01 00 10 3C 4D -> wr_req high 4 cycles with wr_addr=0x010 and wr_data=0x3C; reply AA 01 3C 3D.
- Read with controller model returning 0x1A: send 55 02 03 FF 00 04 -> rd_req high 6 cycles with rd_addr=0x3FF; reply AA 02 1A 1C.
- Save: send 55 03 00 00 00 03 -> one update_req pulse; reply AA 03 00 03; a frame sent during SAVE_WAIT gets no reply and no request.
- Bad checksum: send 55 01 00 10 3C 00 -> no wr_req; err_pulse once; reply AA EE 01 EF.
- Before init_done: valid read frame -> reply AA EE 03 F1, no rd_req. Unknown CMD 0x07 with a correct SUM -> reply AA EE 02 F0.
- Timeout and reset: send 55 01 00 then idle for BYTE_TIMEOUT cycles, then a full valid frame -> only the second frame executes. Assert rst_n low during EXEC_RD -> rd_req drops to 0 immediately.

Source files
------------

// File: rtl/cail_cmd_parser.sv
// UART command front end for the calibration parameter store: decodes 6-byte
// request frames, drives the controller handshakes and returns a 4-byte reply.
module cail_cmd_parser #(
    parameter int          RD_HOLD      = 6,
    parameter int          WR_HOLD      = 4,
    parameter logic [23:0] SAVE_WAIT    = 24'd5_000_000,
    parameter logic [19:0] BYTE_TIMEOUT = 20'd500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_en,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    input  logic       init_done,
    output logic       wr_req,
    output logic [9:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_req,
    output logic [9:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       update_req,
    output logic       err_pulse
);
    typedef enum logic [3:0] {
        RX_HDR, RX_BODY, CHECK, EXEC_WR, EXEC_RD, EXEC_SAVE, TX_LOAD, TX_WAIT, WAIT_SAVE
    } state_t;

    state_t      state, state_nxt;
    logic        ready;
    logic [2:0]  byte_cnt;
    logic [7:0]  checksum;
    logic [7:0]  cmd;
    logic [1:0]  addr_hi;
    logic [7:0]  addr_lo;
    logic [7:0]  data;
    logic [1:0]  err_code;
    logic [1:0]  err_nxt;
    logic [19:0] idle_cnt;
    logic [7:0]  hold_cnt;
    logic [23:0] wait_cnt;
    logic [7:0]  rcmd;
    logic [7:0]  rdata;
    logic [1:0]  tx_idx;
    logic        save_reply;
    logic        hold_last;
    logic [7:0]  reply_byte;

    assign hold_last = (state == EXEC_WR) ? (hold_cnt == 8'(WR_HOLD - 1))
                                          : (hold_cnt == 8'(RD_HOLD - 1));

    // Error code is resolved while the SUM byte arrives so the address outputs
    // can already be updated when CHECK is entered.
    always_comb begin
        if (checksum != rx_data)
            err_nxt = 2'd1;
        else if (cmd == 8'h00 || cmd > 8'h03)
            err_nxt = 2'd2;
        else if (!ready)
            err_nxt = 2'd3;
        else
            err_nxt = 2'd0;
    end

    always_comb begin
        case (tx_idx)
            2'd0:    reply_byte = 8'hAA;
            2'd1:    reply_byte = rcmd;
            2'd2:    reply_byte = rdata;
            default: reply_byte = rcmd + rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RX_HDR;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        tx_en      = 1'b0;
        tx_data    = 8'h00;
        wr_req     = 1'b0;
        rd_req     = 1'b0;
        update_req = 1'b0;
        err_pulse  = 1'b0;
        case (state)
            RX_HDR: begin
                if (rx_valid && rx_data == 8'h55)
                    state_nxt = RX_BODY;
            end
            RX_BODY: begin
                if (rx_valid && byte_cnt == 3'd4)
                    state_nxt = CHECK;
                else if (!rx_valid && idle_cnt == BYTE_TIMEOUT - 20'd1)
                    state_nxt = RX_HDR;
            end
            CHECK: begin
                if (err_code != 2'd0) begin
                    err_pulse = 1'b1;
                    state_nxt = TX_LOAD;
                end else begin
                    case (cmd)
                        8'h01:   state_nxt = EXEC_WR;
                        8'h02:   state_nxt = EXEC_RD;
                        default: state_nxt = EXEC_SAVE;
                    endcase
                end
            end
            EXEC_WR: begin
                wr_req = 1'b1;
                if (hold_last)
                    state_nxt = TX_LOAD;
            end
            EXEC_RD: begin
                rd_req = 1'b1;
                if (hold_last)
                    state_nxt = TX_LOAD;
            end
            EXEC_SAVE: begin
                update_req = 1'b1;
                state_nxt  = TX_LOAD;
            end
            TX_LOAD: begin
                tx_en     = 1'b1;
                tx_data   = reply_byte;
                state_nxt = TX_WAIT;
            end
            TX_WAIT: begin
                tx_data = reply_byte;
                if (tx_done) begin
                    if (tx_idx == 2'd3)
                        state_nxt = save_reply ? WAIT_SAVE : RX_HDR;
                    else
                        state_nxt = TX_LOAD;
                end
            end
            WAIT_SAVE: begin
                if (wait_cnt == SAVE_WAIT - 24'd1)
                    state_nxt = RX_HDR;
            end
            default: state_nxt = RX_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready      <= 1'b0;
            byte_cnt   <= 3'd0;
            checksum   <= 8'h00;
            cmd        <= 8'h00;
            addr_hi    <= 2'd0;
            addr_lo    <= 8'h00;
            data       <= 8'h00;
            err_code   <= 2'd0;
            idle_cnt   <= 20'd0;
            hold_cnt   <= 8'd0;
            wait_cnt   <= 24'd0;
            rcmd       <= 8'h00;
            rdata      <= 8'h00;
            tx_idx     <= 2'd0;
            save_reply <= 1'b0;
            wr_addr    <= 10'd0;
            wr_data    <= 8'h00;
            rd_addr    <= 10'd0;
        end else begin
            if (init_done)
                ready <= 1'b1;
            case (state)
                RX_HDR: begin
                    byte_cnt <= 3'd0;
                    checksum <= 8'h00;
                    idle_cnt <= 20'd0;
                end
                RX_BODY: begin
                    if (rx_valid) begin
                        idle_cnt <= 20'd0;
                        byte_cnt <= byte_cnt + 3'd1;
                        if (byte_cnt != 3'd4)
                            checksum <= checksum + rx_data;
                        case (byte_cnt)
                            3'd0: cmd     <= rx_data;
                            3'd1: addr_hi <= rx_data[1:0];
                            3'd2: addr_lo <= rx_data;
                            3'd3: data    <= rx_data;
                            default: begin
                                err_code   <= err_nxt;
                                save_reply <= (err_nxt == 2'd0 && cmd == 8'h03);
                                if (err_nxt == 2'd0 && cmd == 8'h01) begin
                                    wr_addr <= {addr_hi, addr_lo};
                                    wr_data <= data;
                                end
                                if (err_nxt == 2'd0 && cmd == 8'h02)
                                    rd_addr <= {addr_hi, addr_lo};
                            end
                        endcase
                    end else begin
                        idle_cnt <= idle_cnt + 20'd1;
                    end
                end
                CHECK: begin
                    hold_cnt <= 8'd0;
                    wait_cnt <= 24'd0;
                    tx_idx   <= 2'd0;
                    if (err_code != 2'd0) begin
                        rcmd  <= 8'hEE;
                        rdata <= {6'd0, err_code};
                    end else begin
                        rcmd  <= cmd;
                        rdata <= (cmd == 8'h01) ? data : 8'h00;
                    end
                end
                EXEC_WR: hold_cnt <= hold_cnt + 8'd1;
                EXEC_RD: begin
                    hold_cnt <= hold_cnt + 8'd1;
                    if (hold_last)
                        rdata <= rd_data;
                end
                TX_WAIT: begin
                    if (tx_done && tx_idx != 2'd3)
                        tx_idx <= tx_idx + 2'd1;
                end
                WAIT_SAVE: wait_cnt <= wait_cnt + 24'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cail_cmd_parser.sv
// Self-checking bench for cail_cmd_parser: directed vector table, hand-written
// multi-cycle sequences and randomized frames against a frame-level model.
module tb_cail_cmd_parser;
    localparam int RDH = 6;
    localparam int WRH = 4;
    localparam int SW  = 300;
    localparam int BT  = 100;

    logic       clk;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       init_done;
    logic       wr_req;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [9:0] rd_addr;
    logic [7:0] rd_data;
    logic       update_req;
    logic       err_pulse;

    cail_cmd_parser #(
        .RD_HOLD(RDH), .WR_HOLD(WRH),
        .SAVE_WAIT(24'(SW)), .BYTE_TIMEOUT(20'(BT))
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_en(tx_en), .tx_data(tx_data), .tx_done(tx_done), .init_done(init_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
        .update_req(update_req), .err_pulse(err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Controller model: returns rd_val only on the last held rd_req cycle.
    int         rd_cnt = 0;
    logic [7:0] rd_val = 8'h1A;
    always @(posedge clk) rd_cnt <= rd_req ? rd_cnt + 1 : 0;
    assign rd_data = (rd_cnt == RDH - 1) ? rd_val : ~rd_val;

    // Transmitter model: tx_done three cycles after each tx_en.
    int tx_dly = 0;
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (tx_dly > 0) begin
                tx_dly--;
                if (tx_dly == 0) tx_done = 1'b1;
            end
            if (tx_en) tx_dly = 3;
        end
    end

    logic [7:0] txq[$];
    int n_wr = 0, n_rd = 0, n_upd = 0, n_err = 0, n_overlap = 0;
    logic [9:0] last_wa = '0, last_ra = '0;
    logic [7:0] last_wd = '0;
    always @(negedge clk) begin
        if (tx_en) txq.push_back(tx_data);
        if (wr_req) begin n_wr++; last_wa = wr_addr; last_wd = wr_data; end
        if (rd_req) begin n_rd++; last_ra = rd_addr; end
        if (update_req) n_upd++;
        if (err_pulse) n_err++;
        if ((wr_req && rd_req) || (update_req && (wr_req || rd_req))) n_overlap++;
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_init();
        @(negedge clk);
        init_done = 1'b1;
        @(negedge clk);
        init_done = 1'b0;
    endtask

    // Frame-level reference: reply {AA,RCMD,RDATA,RSUM}; kind 0=error,1=wr,2=rd,3=save.
    function automatic logic [31:0] model(input logic [47:0] fr, input bit rdy,
                                          input logic [7:0] rdv, output int kind);
        logic [7:0] c, s, rc, rdt;
        c = fr[39:32];
        s = fr[39:32] + fr[31:24] + fr[23:16] + fr[15:8];
        kind = 0;
        if (s != fr[7:0]) begin rc = 8'hEE; rdt = 8'h01; end
        else if (c < 8'h01 || c > 8'h03) begin rc = 8'hEE; rdt = 8'h02; end
        else if (!rdy) begin rc = 8'hEE; rdt = 8'h03; end
        else begin
            kind = int'(c);
            rc   = c;
            rdt  = (c == 8'h01) ? fr[15:8] : (c == 8'h02) ? rdv : 8'h00;
        end
        return {8'hAA, rc, rdt, 8'(rc + rdt)};
    endfunction

    task automatic run_frame(input string name, input logic [47:0] fr, input logic [31:0] rep,
                             input int kind, input logic [9:0] addr, input logic [7:0] dat,
                             input int gap);
        int t0, w0, r0, u0, e0, cyc;
        t0 = txq.size(); w0 = n_wr; r0 = n_rd; u0 = n_upd; e0 = n_err;
        for (int i = 5; i >= 0; i--) send_byte(fr[i*8 +: 8], gap);
        cyc = 0;
        while (txq.size() < t0 + 4 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (8) @(negedge clk);
        check({name, " tx byte count"}, 32'(txq.size() - t0), 32'd4);
        if (txq.size() >= t0 + 4)
            check({name, " reply"}, {txq[t0], txq[t0+1], txq[t0+2], txq[t0+3]}, rep);
        check({name, " wr_req cycles"}, 32'(n_wr - w0), (kind == 1) ? 32'(WRH) : 32'd0);
        check({name, " rd_req cycles"}, 32'(n_rd - r0), (kind == 2) ? 32'(RDH) : 32'd0);
        check({name, " update_req pulses"}, 32'(n_upd - u0), (kind == 3) ? 32'd1 : 32'd0);
        check({name, " err_pulse count"}, 32'(n_err - e0), (kind == 0) ? 32'd1 : 32'd0);
        if (kind == 1) begin
            check({name, " wr_addr"}, 32'(last_wa), 32'(addr));
            check({name, " wr_data"}, 32'(last_wd), 32'(dat));
        end
        if (kind == 2)
            check({name, " rd_addr"}, 32'(last_ra), 32'(addr));
    endtask

    typedef struct {
        logic [47:0] fr;
        logic [31:0] rep;
        int          kind;
        logic [9:0]  addr;
        logic [7:0]  dat;
    } vec_t;
    vec_t vt[9];

    bit          ready_m;
    logic [47:0] fr;
    logic [31:0] rep;
    logic [7:0]  c, ah, al, d, s, g;
    int          kind, t0, w0, cyc;

    initial begin
        vt[0] = '{48'h55_01_00_10_3C_4D, 32'hAA_01_3C_3D, 1, 10'h010, 8'h3C};
        vt[1] = '{48'h55_02_03_FF_00_04, 32'hAA_02_1A_1C, 2, 10'h3FF, 8'h00};
        vt[2] = '{48'h55_01_00_10_3C_00, 32'hAA_EE_01_EF, 0, 10'h000, 8'h00};
        vt[3] = '{48'h55_07_00_00_00_07, 32'hAA_EE_02_F0, 0, 10'h000, 8'h00};
        vt[4] = '{48'h55_01_FE_20_77_96, 32'hAA_01_77_78, 1, 10'h220, 8'h77};
        vt[5] = '{48'h55_01_01_55_55_AC, 32'hAA_01_55_56, 1, 10'h155, 8'h55};
        vt[6] = '{48'h55_09_00_00_00_00, 32'hAA_EE_01_EF, 0, 10'h000, 8'h00};
        vt[7] = '{48'h55_02_00_00_00_02, 32'hAA_02_1A_1C, 2, 10'h000, 8'h00};
        vt[8] = '{48'h55_00_00_00_00_00, 32'hAA_EE_02_F0, 0, 10'h000, 8'h00};

        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; init_done = 1'b0;
        ready_m = 1'b0;
        repeat (3) @(negedge clk);
        check("reset strobes", 32'({tx_en, wr_req, rd_req, update_req, err_pulse}), 32'd0);
        check("reset tx_data", 32'(tx_data), 32'd0);
        check("reset addresses", 32'({wr_addr, rd_addr}), 32'd0);
        check("reset wr_data", 32'(wr_data), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Before init_done: not-ready and error priority.
        run_frame("preinit read", 48'h55_02_03_FF_00_04, 32'hAA_EE_03_F1, 0, 0, 0, 1);
        run_frame("preinit unknown", 48'h55_07_00_00_00_07, 32'hAA_EE_02_F0, 0, 0, 0, 0);
        run_frame("preinit badsum", 48'h55_02_03_FF_00_00, 32'hAA_EE_01_EF, 0, 0, 0, 2);

        pulse_init();
        ready_m = 1'b1;
        rd_val  = 8'h1A;
        for (int i = 0; i < 9; i++)
            run_frame($sformatf("vec%0d", i), vt[i].fr, vt[i].rep, vt[i].kind,
                      vt[i].addr, vt[i].dat, i % 3);
        @(negedge clk);
        check("wr_addr held across other frames", 32'(wr_addr), 32'h155);

        // Save, then a frame inside the save window must be ignored.
        run_frame("save", 48'h55_03_00_00_00_03, 32'hAA_03_00_03, 3, 0, 0, 0);
        t0 = txq.size(); w0 = n_wr;
        fr = 48'h55_01_00_10_3C_4D;
        for (int i = 5; i >= 0; i--) send_byte(fr[i*8 +: 8], 1);
        repeat (30) @(negedge clk);
        check("save window reply", 32'(txq.size() - t0), 32'd0);
        check("save window wr_req", 32'(n_wr - w0), 32'd0);
        repeat (SW + 10) @(negedge clk);
        run_frame("after save", vt[0].fr, vt[0].rep, 1, 10'h010, 8'h3C, 0);

        // Inter-byte timeout discards a partial frame; a gap just under it does not.
        send_byte(8'h55, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
        repeat (BT + 5) @(negedge clk);
        run_frame("after timeout", vt[0].fr, vt[0].rep, 1, 10'h010, 8'h3C, 0);
        run_frame("long gap", vt[4].fr, vt[4].rep, 1, 10'h220, 8'h77, BT - 3);

        // Randomized frames against the model.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: c = 8'h01;
                4, 5, 6:    c = 8'h02;
                7:          c = 8'h00;
                default:    c = 8'($urandom_range(4, 255));
            endcase
            ah = 8'($urandom); al = 8'($urandom); d = 8'($urandom);
            s  = c + ah + al + d;
            if ($urandom_range(0, 4) == 0) s = 8'($urandom);
            rd_val = 8'($urandom);
            fr  = {8'h55, c, ah, al, d, s};
            rep = model(fr, ready_m, rd_val, kind);
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                g = 8'($urandom);
                if (g == 8'h55) g = 8'h00;
                send_byte(g, 0);
            end
            run_frame($sformatf("rand%0d", i), fr, rep, kind, {ah[1:0], al}, d,
                      $urandom_range(0, 3));
        end

        // Asynchronous reset in the middle of a read.
        rd_val = 8'h1A;
        t0 = txq.size();
        fr = 48'h55_02_03_FF_00_04;
        for (int i = 5; i >= 0; i--) send_byte(fr[i*8 +: 8], 0);
        cyc = 0;
        while (!rd_req && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("rst: rd_req reached", 32'(rd_req), 32'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst: rd_req drops immediately", 32'(rd_req), 32'd0);
        check("rst: other strobes", 32'({wr_req, update_req, tx_en}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ready_m = 1'b0;
        repeat (40) @(negedge clk);
        check("rst: aborted read sends nothing", 32'(txq.size() - t0), 32'd0);
        run_frame("post-reset not ready", vt[0].fr, 32'hAA_EE_03_F1, 0, 0, 0, 0);
        pulse_init();
        ready_m = 1'b1;
        run_frame("post-reset write", vt[0].fr, vt[0].rep, 1, 10'h010, 8'h3C, 0);

        check("request overlap cycles", 32'(n_overlap), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
